// File: rtl/bin_to_bcd_seq_if.sv
// Start/done handshake bundle between a binary source and the BCD converter.
// The master drives the request and the value; the slave returns status and digits.
interface bin_to_bcd_seq_if #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin_in, input busy, done, bcd);
  modport slave  (input start, bin_in, output busy, done, bcd);
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter: one bit per clock,
// result registered and held stable between done pulses for the display path.
module bin_to_bcd_seq #(
  parameter int BIN_W  = 10,
  parameter int DIGITS = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  bin_to_bcd_seq_if.slave   bus
);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e                   state_q;
  logic [BIN_W-1:0]         bin_q;
  logic [BIN_W-1:0]         bin_d;
  logic [BCD_W-1:0]         scratch_q;
  logic [BCD_W-1:0]         scratch_d;
  logic [BCD_W-1:0]         adj_s;
  logic [BCD_W+BIN_W-1:0]   shifted_s;
  logic [CNT_W-1:0]         count_q;
  logic                     busy_q;
  logic                     done_q;
  logic [BCD_W-1:0]         bcd_q;

  // Digits are corrected independently; no carry ever crosses a nibble boundary.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = v[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  // One double-dabble step: correct digits, then shift {scratch, binary} left.
  always_comb begin
    adj_s     = add3_digits(scratch_q);
    shifted_s = {adj_s, bin_q} << 1;
    scratch_d = shifted_s[BCD_W+BIN_W-1:BIN_W];
    bin_d     = shifted_s[BIN_W-1:0];
  end

  // Control FSM with registered handshake outputs and result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bin_q     <= '0;
      scratch_q <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bcd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            bin_q     <= bus.bin_in;
            scratch_q <= '0;
            count_q   <= '0;
            busy_q    <= 1'b1;
            state_q   <= SHIFT;
          end else begin
            busy_q    <= 1'b0;
          end
        end
        SHIFT: begin
          bin_q     <= bin_d;
          scratch_q <= scratch_d;
          count_q   <= count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          // Final shift: publish the post-shift scratch value directly.
          if (count_q == CNT_W'(BIN_W - 1)) begin
            bcd_q   <= scratch_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            busy_q  <= 1'b1;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed and randomized checks of the sequential binary-to-BCD converter,
// including latency, ignored starts, and mid-conversion reset.
module tb_bin_to_bcd_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bin_to_bcd_seq_if #(.BIN_W(10), .DIGITS(4)) bus ();

  bin_to_bcd_seq #(.BIN_W(10), .DIGITS(4), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'(v / 1000);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  // Full conversion with exact latency checks; assumes the DUT is idle.
  task automatic convert(input logic [9:0] v, input logic [15:0] exp, input string nm);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = v;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL %s busy cycle %0d: busy=%b done=%b, need busy=1 done=0", nm, i, bus.busy, bus.done);
      end
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.bcd !== exp) begin
      errors++;
      $display("FAIL %s done: done=%b busy=%b bcd=%h, need done=1 busy=0 bcd=%h", nm, bus.done, bus.busy, bus.bcd, exp);
    end
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b0 || bus.bcd !== exp) begin
      errors++;
      $display("FAIL %s hold: done=%b bcd=%h, need done=0 bcd=%h", nm, bus.done, bus.bcd, exp);
    end
  endtask

  task automatic test_reset();
    int pulses;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bin_in = 10'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 16'h0000) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b bcd=%h, need 0 0 0000", bus.busy, bus.done, bus.bcd);
    end
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy !== 1'b0 || bus.bcd !== 16'h0000) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL idle_stable: %0d disturbed cycles, need 0", pulses);
    end
  endtask

  task automatic test_max();
    convert(10'd1023, 16'h1023, "max_1023");
  endtask

  task automatic test_values();
    convert(10'd0,   16'h0000, "val_0");
    convert(10'd9,   16'h0009, "val_9");
    convert(10'd10,  16'h0010, "val_10");
    convert(10'd99,  16'h0099, "val_99");
    convert(10'd100, 16'h0100, "val_100");
    convert(10'd999, 16'h0999, "val_999");
    convert(10'd512, 16'h0512, "val_512");
    repeat (5) @(negedge clk);
    checks++;
    if (bus.bcd !== 16'h0512) begin
      errors++;
      $display("FAIL idle_hold: bcd=%h, need 0512", bus.bcd);
    end
  endtask

  task automatic test_ignore_start();
    int          pulses;
    logic [15:0] seen;
    seen = 16'hxxxx;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 10'd255;
    @(posedge clk);
    #1 bus.start = 1'b0;
    bus.bin_in = 10'd777;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        seen = bus.bcd;
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL ignore_start pulses: got %0d, need 1", pulses);
    end
    checks++;
    if (seen !== 16'h0255) begin
      errors++;
      $display("FAIL ignore_start bcd: got %h, need 0255", seen);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 10'd600;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.bcd !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b bcd=%h, need 0 0 0000", bus.busy, bus.done, bus.bcd);
    end
    @(negedge clk);
    rst    = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0) begin
      errors++;
      $display("FAIL reset_mid_quiet: %0d active cycles, need 0", pulses);
    end
    convert(10'd42, 16'h0042, "after_reset_42");
  endtask

  task automatic test_back_to_back();
    int pulses;
    int last;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 10'd321;
    pulses = 0;
    last   = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        pulses++;
        checks++;
        if (bus.bcd !== 16'h0321 || (last >= 0 && i - last != 12)) begin
          errors++;
          $display("FAIL back_to_back pulse %0d: bcd=%h interval=%0d, need 0321 interval 12", pulses, bus.bcd, i - last);
        end
        last = i;
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++;
      $display("FAIL back_to_back count: got %0d pulses, need 4", pulses);
    end
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
  endtask

  task automatic test_random();
    int v;
    for (int n = 0; n < 200; n++) begin
      v = int'($urandom_range(0, 1023));
      convert(10'(v), ref_bcd(v), "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_max();
    test_values();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
